// File: rtl/plaintext_packer.sv
// rtl/plaintext_packer.sv - byte FIFO feeding a 4-lane word packer with flush of partial words.
// Define PACKER_MSB_FIRST_EN to place the first byte in the most significant lane.
module plaintext_packer #(
  parameter int SYS_DWIDTH = 8,
  parameter int MST_DWIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_WIDTH  = 5
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [SYS_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  flush_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [2:0]            bytes_o,
  output logic                  last_o,
  output logic                  overflow_o,
  output logic [LVL_WIDTH-1:0]  level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(FIFO_DEPTH);

  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_nxt;

  logic [SYS_DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LVL_WIDTH-1:0]  level;
  logic [MST_DWIDTH-1:0] acc, acc_nxt, data_nxt, lane_word;
  logic [1:0]            cnt, cnt_nxt;
  logic [2:0]            bytes_nxt;
  logic                  last_nxt, flush_pend, flush_clr;
  logic                  empty, full, pop, push;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign pop     = !empty && (!valid_o || ready_i);
  assign push    = valid_i && (!full || pop);
  assign level_o = level;
  assign valid_o = (state == HOLD);

  // Head byte shifted into lane cnt; padding lanes stay zero because acc clears per word
`ifdef PACKER_MSB_FIRST_EN
  assign lane_word = MST_DWIDTH'(mem[rd_ptr]) << {~cnt, 3'b000};
`else
  assign lane_word = MST_DWIDTH'(mem[rd_ptr]) << {cnt, 3'b000};
`endif

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LVL_WIDTH'(1);
      else if (pop && !push) level <= level - LVL_WIDTH'(1);
      if (valid_i && !push)  overflow_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    data_nxt  = data_o;
    bytes_nxt = bytes_o;
    last_nxt  = last_o;
    flush_clr = 1'b0;
    if (state == HOLD && ready_i) state_nxt = COLLECT;
    if (pop) begin
      if (cnt == 2'd3) begin
        data_nxt  = acc | lane_word;
        bytes_nxt = 3'd4;
        last_nxt  = 1'b0;
        acc_nxt   = '0;
        cnt_nxt   = 2'd0;
        state_nxt = HOLD;
      end else begin
        acc_nxt = acc | lane_word;
        cnt_nxt = cnt + 2'd1;
      end
    end else if (state == COLLECT && flush_pend && empty) begin
      // Pipeline fully drained: emit whatever is in the lanes, or just retire the request
      flush_clr = 1'b1;
      if (cnt != 2'd0) begin
        data_nxt  = acc;
        bytes_nxt = {1'b0, cnt};
        last_nxt  = 1'b1;
        acc_nxt   = '0;
        cnt_nxt   = 2'd0;
        state_nxt = HOLD;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      acc        <= '0;
      cnt        <= 2'd0;
      data_o     <= '0;
      bytes_o    <= 3'd0;
      last_o     <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      data_o     <= data_nxt;
      bytes_o    <= bytes_nxt;
      last_o     <= last_nxt;
      flush_pend <= flush_clr ? 1'b0 : (flush_pend | flush_i);
    end
  end
endmodule

// File: tb/tb_plaintext_packer.sv
// tb/tb_plaintext_packer.sv - scoreboard bench for plaintext_packer.
// Define PACKER_MSB_FIRST_EN for both bench and RTL to exercise MSB-first lanes.
module tb_plaintext_packer;
  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [2:0]  bytes_o;
  logic        last_o;
  logic        overflow_o;
  logic [4:0]  level_o;

  plaintext_packer dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .flush_i(flush_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .bytes_o(bytes_o), .last_o(last_o), .overflow_o(overflow_o), .level_o(level_o)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] macc = '0;
  int          mcnt = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_bytes;
  logic        prev_last;

  function automatic logic [31:0] place(input logic [7:0] b, input int lane);
`ifdef PACKER_MSB_FIRST_EN
    return {24'h0, b} << (8 * (3 - lane));
`else
    return {24'h0, b} << (8 * lane);
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    macc = macc | place(b, mcnt);
    mcnt++;
    if (mcnt == 4) begin
      sb.push_back('{data: macc, bytes: 3'd4, last: 1'b0});
      macc = '0;
      mcnt = 0;
    end
  endtask

  task automatic model_flush();
    if (mcnt > 0) sb.push_back('{data: macc, bytes: 3'(mcnt), last: 1'b1});
    macc = '0;
    mcnt = 0;
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit accepted);
    data_i  = b;
    valid_i = 1'b1;
    if (accepted) model_byte(b);
    step();
  endtask

  task automatic pulse_flush();
    valid_i = 1'b0;
    flush_i = 1'b1;
    model_flush();
    step();
    flush_i = 1'b0;
  endtask

  task automatic wait_drain(input bit toggle);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      if (toggle) ready_i = ~ready_i;
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  // Scoreboard pop on each handshake, plus output stability while stalled
  always @(negedge clk_sys) begin
    exp_t e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== prev_data || bytes_o !== prev_bytes || last_o !== prev_last) begin
          errors++;
          $display("FAIL hold_stable got v=%b d=%h b=%0d l=%b required v=1 d=%h b=%0d l=%b",
                   valid_o, data_o, bytes_o, last_o, prev_data, prev_bytes, prev_last);
        end
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got d=%h b=%0d l=%b required none", data_o, bytes_o, last_o);
        end else begin
          e = sb.pop_front();
          if ({data_o, bytes_o, last_o} !== e) begin
            errors++;
            $display("FAIL word got d=%h b=%0d l=%b required d=%h b=%0d l=%b",
                     data_o, bytes_o, last_o, e.data, e.bytes, e.last);
          end
        end
      end
      hold_prev  = valid_o && !ready_i;
      prev_data  = data_o;
      prev_bytes = bytes_o;
      prev_last  = last_o;
    end
  end

  task automatic test_reset();
    #2;
    checks++;
    if ({data_o, valid_o, bytes_o, last_o, overflow_o, level_o} !== '0) begin
      errors++;
      $display("FAIL reset_values got d=%h v=%b b=%0d l=%b o=%b lvl=%0d required all 0",
               data_o, valid_o, bytes_o, last_o, overflow_o, level_o);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    logic [31:0] want;
`ifdef PACKER_MSB_FIRST_EN
    want = 32'h11223344;
`else
    want = 32'h44332211;
`endif
    ready_i = 1'b1;
    drive_byte(8'h11, 1);
    drive_byte(8'h22, 1);
    drive_byte(8'h33, 1);
    drive_byte(8'h44, 1);
    valid_i = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_c1 got valid=%b required 0", valid_o);
    end
    step();
    @(negedge clk_sys);
    checks++;
    if (valid_o !== 1'b1 || data_o !== want || bytes_o !== 3'd4 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_c2 got v=%b d=%h b=%0d l=%b required v=1 d=%h b=4 l=0",
               valid_o, data_o, bytes_o, last_o, want);
    end
    step();
    @(negedge clk_sys);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_one_cycle got valid=%b required 0", valid_o);
    end
    wait_drain(0);
  endtask

  task automatic test_flush();
    ready_i = 1'b1;
    drive_byte(8'hAA, 1);
    drive_byte(8'hBB, 1);
    drive_byte(8'hCC, 1);
    pulse_flush();
    wait_drain(0);
    drive_byte(8'h11, 1);
    pulse_flush();
    wait_drain(0);
    step();
    step();
    pulse_flush();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty got valid=%b required 0", valid_o);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int max_lvl = 0;
    ready_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive_byte(8'($urandom_range(0, 255)), 1);
      if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
    end
    valid_i = 1'b0;
    wait_drain(0);
    checks++;
    if (max_lvl > 1) begin
      errors++;
      $display("FAIL throughput_level got max=%0d required <=1", max_lvl);
    end
  endtask

  task automatic test_overflow();
    ready_i = 1'b0;
    // Bytes 0..3 reach the output register, 4..19 fill the FIFO, 20..23 are dropped
    for (int i = 0; i < 24; i++) drive_byte(8'(8'h40 + i), i < 20);
    valid_i = 1'b0;
    for (int i = 0; i < 16; i++) step();
    @(negedge clk_sys);
    checks++;
    if (overflow_o !== 1'b1 || level_o !== 5'd16) begin
      errors++;
      $display("FAIL overflow got ovf=%b lvl=%0d required ovf=1 lvl=16", overflow_o, level_o);
    end
    step();
    ready_i = 1'b1;
    wait_drain(0);
    step();
    checks++;
    if (level_o !== 5'd0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after got lvl=%0d ovf=%b required lvl=0 ovf=1", level_o, overflow_o);
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) drive_byte(8'(8'h80 + i), 1);
    valid_i = 1'b0;
    step();
    step();
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got valid=%b required 1", valid_o);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_o, valid_o, bytes_o, last_o, overflow_o, level_o} !== '0) begin
      errors++;
      $display("FAIL reset_async got d=%h v=%b b=%0d l=%b o=%b lvl=%0d required all 0",
               data_o, valid_o, bytes_o, last_o, overflow_o, level_o);
    end
    sb.delete();
    macc = '0;
    mcnt = 0;
    step();
    step();
    rst_n = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) drive_byte(8'(8'hC0 + i), 1);
    valid_i = 1'b0;
    wait_drain(0);
  endtask

  task automatic test_toggle_ready();
    ready_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ready_i = ~ready_i;
      drive_byte(8'($urandom_range(0, 255)), 1);
    end
    valid_i = 1'b0;
    wait_drain(1);
    checks++;
    if (overflow_o !== 1'b0 || level_o !== 5'd0) begin
      errors++;
      $display("FAIL toggle_no_loss got ovf=%b lvl=%0d required ovf=0 lvl=0", overflow_o, level_o);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flush();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_toggle_ready();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
